// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: holds one instruction, retires it exactly once, commits GPR/CSR
// writes, raises exception/ertn flushes and records every retirement in a difftest FIFO.
module wb_retire_unit #(
  parameter int DATA_W      = 32,
  parameter int EXCP_N      = 6,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  // Handshake: a beat transfers on a rising edge where in_valid && in_ready. in_ready depends
  // only on stage state, never on in_valid; the sender holds its beat until it transfers.
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_pc,
  input  logic                           in_gr_we,
  input  logic [4:0]                     in_dest,
  input  logic [DATA_W-1:0]              in_result,
  input  logic                           in_ertn,
  input  logic                           in_csr_we,
  input  logic [13:0]                    in_csr_num,
  input  logic [DATA_W-1:0]              in_csr_wdata,
  input  logic [EXCP_N-1:0]              in_excp,
  output logic                           rf_we,
  output logic [4:0]                     rf_waddr,
  output logic [DATA_W-1:0]              rf_wdata,
  output logic [4:0]                     fwd_dest,
  output logic [DATA_W-1:0]              fwd_data,
  output logic                           csr_we,
  output logic [13:0]                    csr_num,
  output logic [DATA_W-1:0]              csr_wvalue,
  output logic                           excp_flush,
  output logic                           ertn_flush,
  output logic [5:0]                     ecode,
  output logic [8:0]                     esubcode,
  output logic                           sys_pending,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic [DATA_W-1:0]              trace_pc,
  output logic [3:0]                     trace_we,
  output logic [4:0]                     trace_wnum,
  output logic [DATA_W-1:0]              trace_wdata,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * DATA_W + 9;

  logic                valid;
  logic                shadow;
  logic [DATA_W-1:0]   pc_r;
  logic                gr_we_r;
  logic [4:0]          dest_r;
  logic [DATA_W-1:0]   result_r;
  logic                ertn_r;
  logic                csr_we_r;
  logic [13:0]         csr_num_r;
  logic [DATA_W-1:0]   csr_wdata_r;
  logic [EXCP_N-1:0]   excp_r;

  logic [RW-1:0]       mem [TRACE_DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [CW-1:0]       count;

  logic                ready_go;
  logic                retire;
  logic                has_excp;
  logic                push;
  logic                pop;
  logic [5:0]          ecode_c;
  logic                badv_c;
  logic                sys_c;

  assign ready_go = (count != CW'(TRACE_DEPTH));
  assign in_ready = !valid || ready_go;
  assign retire   = valid && ready_go;
  assign has_excp = |excp_r;

  // The shadow flag marks the cycle after a flush; a beat accepted then is wrong-path.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      shadow <= 1'b0;
    end else begin
      shadow <= excp_flush || ertn_flush;
      if (in_ready) valid <= in_valid && !shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      pc_r        <= in_pc;
      gr_we_r     <= in_gr_we;
      dest_r      <= in_dest;
      result_r    <= in_result;
      ertn_r      <= in_ertn;
      csr_we_r    <= in_csr_we;
      csr_num_r   <= in_csr_num;
      csr_wdata_r <= in_csr_wdata;
      excp_r      <= in_excp;
    end
  end

  // Scan from the top bit down so the lowest set bit (highest priority) is applied last.
  always_comb begin
    ecode_c = 6'h00;
    badv_c  = 1'b0;
    sys_c   = 1'b0;
    for (int i = EXCP_N - 1; i >= 0; i--) begin
      if (i == 3) sys_c = excp_r[i];
      if (excp_r[i]) begin
        badv_c = 1'b0;
        case (i)
          0:       ecode_c = 6'h00;
          1:       begin ecode_c = 6'h08; badv_c = 1'b1; end
          2:       ecode_c = 6'h0c;
          3:       ecode_c = 6'h0b;
          4:       ecode_c = 6'h0d;
          5:       begin ecode_c = 6'h09; badv_c = 1'b1; end
          default: ecode_c = 6'h00;
        endcase
      end
    end
  end

  assign ecode       = ecode_c;
  assign esubcode    = 9'h000;
  assign excp_flush  = retire && has_excp;
  assign ertn_flush  = retire && ertn_r && !has_excp;
  assign sys_pending = valid && (ertn_r || sys_c);

  assign rf_we    = retire && gr_we_r && !has_excp;
  assign rf_waddr = dest_r;
  assign rf_wdata = result_r;
  assign fwd_dest = (valid && gr_we_r && !has_excp) ? dest_r : 5'd0;
  assign fwd_data = result_r;

  // An exception replaces the software CSR write with the BADV update when it applies.
  assign csr_we     = retire && (has_excp ? badv_c : csr_we_r);
  assign csr_num    = (has_excp && badv_c) ? 14'h0007 : csr_num_r;
  assign csr_wvalue = (has_excp && badv_c) ? pc_r : csr_wdata_r;

  assign push = retire;
  assign pop  = (count != '0) && trace_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {pc_r, {4{rf_we}}, dest_r, result_r};
  end

  assign {trace_pc, trace_we, trace_wnum, trace_wdata} = mem[rptr];
  assign trace_valid = (count != '0);
  assign trace_count = count;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Bench for wb_retire_unit: directed scenarios plus randomized traffic, all outputs compared
// each cycle against a queue-based reference model of the retire stage and trace FIFO.
module tb_wb_retire_unit;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [5:0] ECODE_TAB [6] = '{6'h00, 6'h08, 6'h0c, 6'h0b, 6'h0d, 6'h09};

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ertn;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic [5:0]  excp;
  } ins_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [DW-1:0] in_pc, in_result, in_csr_wdata;
  logic in_gr_we, in_ertn, in_csr_we;
  logic [4:0] in_dest;
  logic [13:0] in_csr_num;
  logic [5:0] in_excp;
  logic rf_we, csr_we, excp_flush, ertn_flush, sys_pending, trace_valid, trace_ready;
  logic [4:0] rf_waddr, fwd_dest, trace_wnum;
  logic [DW-1:0] rf_wdata, fwd_data, csr_wvalue, trace_pc, trace_wdata;
  logic [13:0] csr_num;
  logic [5:0] ecode;
  logic [8:0] esubcode;
  logic [3:0] trace_we;
  logic [2:0] trace_count;

  int total = 0;
  int bad = 0;

  wb_retire_unit #(.DATA_W(DW), .EXCP_N(6), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_gr_we(in_gr_we),
    .in_dest(in_dest), .in_result(in_result), .in_ertn(in_ertn), .in_csr_we(in_csr_we),
    .in_csr_num(in_csr_num), .in_csr_wdata(in_csr_wdata), .in_excp(in_excp),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wvalue(csr_wvalue),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode), .esubcode(esubcode),
    .sys_pending(sys_pending),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_we(trace_we), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata),
    .trace_count(trace_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input ins_t b);
    in_valid     = 1'b1;
    in_pc        = b.pc;
    in_gr_we     = b.gr_we;
    in_dest      = b.dest;
    in_result    = b.result;
    in_ertn      = b.ertn;
    in_csr_we    = b.csr_we;
    in_csr_num   = b.csr_num;
    in_csr_wdata = b.csr_wdata;
    in_excp      = b.excp;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Present a beat and return one cycle after it transfers.
  task automatic send(input ins_t b);
    apply(b);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        return;
      end
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask

  function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    ins_t b;
    b = '0;
    b.pc = pc;
    b.gr_we = 1'b1;
    b.dest = d;
    b.result = r;
    return b;
  endfunction

  function automatic ins_t rand_beat();
    ins_t b;
    b.pc        = $urandom() & 32'hffff_fffc;
    b.gr_we     = 1'($urandom_range(0, 1));
    b.dest      = 5'($urandom_range(0, 31));
    b.result    = $urandom();
    b.ertn      = ($urandom_range(0, 9) == 0);
    b.csr_we    = ($urandom_range(0, 9) < 3);
    b.csr_num   = 14'($urandom_range(0, 16383));
    b.csr_wdata = $urandom();
    b.excp      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'h00;
    return b;
  endfunction

  // Reference model: one held instruction, a wrong-path flag, and the trace FIFO as a queue.
  bit m_valid;
  bit m_shadow;
  ins_t m_ins;
  rec_t exp_q[$];
  bit m_full, m_ret, m_hx, m_bv, e_rf, e_csr, e_xf, e_ef;
  logic [5:0] e_code;
  rec_t m_rec;

  function automatic void decode(input logic [5:0] e, output logic [5:0] code, output bit bv);
    code = 6'h00;
    bv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (e[i]) begin
        code = ECODE_TAB[i];
        bv = (i == 1) || (i == 5);
        return;
      end
    end
  endfunction

  // Scoreboard
  always @(negedge clk) begin
    if (reset) begin
      m_valid = 1'b0;
      m_shadow = 1'b0;
      exp_q.delete();
    end else begin
      m_full = (exp_q.size() == DEPTH);
      m_ret  = m_valid && !m_full;
      m_hx   = m_valid && (m_ins.excp != 6'h00);
      decode(m_ins.excp, e_code, m_bv);
      e_rf  = m_ret && m_ins.gr_we && !m_hx;
      e_csr = m_ret && (m_hx ? m_bv : m_ins.csr_we);
      e_xf  = m_ret && m_hx;
      e_ef  = m_ret && m_ins.ertn && !m_hx;

      check("in_ready", in_ready, !m_valid || !m_full);
      check("rf_we", rf_we, e_rf);
      if (e_rf) begin
        check("rf_waddr", rf_waddr, m_ins.dest);
        check("rf_wdata", rf_wdata, m_ins.result);
      end
      check("csr_we", csr_we, e_csr);
      if (e_csr) begin
        check("csr_num", csr_num, m_hx ? 14'h7 : m_ins.csr_num);
        check("csr_wvalue", csr_wvalue, m_hx ? m_ins.pc : m_ins.csr_wdata);
      end
      check("excp_flush", excp_flush, e_xf);
      check("ertn_flush", ertn_flush, e_ef);
      if (m_valid) begin
        check("ecode", ecode, e_code);
        check("esubcode", esubcode, 9'h0);
        check("fwd_data", fwd_data, m_ins.result);
      end
      check("fwd_dest", fwd_dest, (m_valid && m_ins.gr_we && !m_hx) ? m_ins.dest : 5'd0);
      check("sys_pending", sys_pending, m_valid && (m_ins.ertn || m_ins.excp[3]));
      check("trace_count", trace_count, exp_q.size());
      check("trace_valid", trace_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("trace_pc", trace_pc, exp_q[0].pc);
        check("trace_we", trace_we, exp_q[0].we);
        check("trace_wnum", trace_wnum, exp_q[0].wnum);
        check("trace_wdata", trace_wdata, exp_q[0].wdata);
      end

      if (exp_q.size() != 0 && trace_ready) void'(exp_q.pop_front());
      if (m_ret) begin
        m_rec.pc = m_ins.pc;
        m_rec.we = e_rf ? 4'hf : 4'h0;
        m_rec.wnum = m_ins.dest;
        m_rec.wdata = m_ins.result;
        exp_q.push_back(m_rec);
      end
      if (!m_valid || !m_full) begin
        if (in_valid && !m_shadow) begin
          m_valid = 1'b1;
          m_ins = '{in_pc, in_gr_we, in_dest, in_result, in_ertn, in_csr_we,
                    in_csr_num, in_csr_wdata, in_excp};
        end else begin
          m_valid = 1'b0;
        end
      end
      m_shadow = e_xf || e_ef;
    end
  end

  ins_t b, bs [9];
  logic [31:0] got [$];
  int hits;
  bit hold;

  initial begin
    reset = 1'b1;
    trace_ready = 1'b0;
    apply('0);
    idle();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_count", trace_count, 3'd0);
    check("rst_trace_valid", trace_valid, 1'b0);
    check("rst_flushes", {excp_flush, ertn_flush, rf_we, csr_we}, 4'b0000);

    // back-to-back ALU ops
    trace_ready = 1'b1;
    send(alu(32'h1c00_0000, 5'd1, 32'd5));
    check("alu1_we", rf_we, 1'b1);
    check("alu1_addr", rf_waddr, 5'd1);
    check("alu1_data", rf_wdata, 32'd5);
    send(alu(32'h1c00_0004, 5'd2, 32'd7));
    check("alu2_we", rf_we, 1'b1);
    check("alu2_addr", rf_waddr, 5'd2);
    check("alu2_data", rf_wdata, 32'd7);
    check("alu_trace0", trace_pc, 32'h1c00_0000);
    idle();
    tick();
    check("alu_trace1", trace_pc, 32'h1c00_0004);
    tick();

    // ADEF + BRK: ADEF wins and updates BADV
    b = alu(32'h1c00_0010, 5'd3, 32'h55);
    b.excp = 6'b000110;
    b.csr_we = 1'b1;
    b.csr_num = 14'h0123;
    send(b);
    check("adef_ecode", ecode, 6'h08);
    check("adef_csr_we", csr_we, 1'b1);
    check("adef_csr_num", csr_num, 14'h7);
    check("adef_csr_val", csr_wvalue, 32'h1c00_0010);
    check("adef_rf_we", rf_we, 1'b0);
    check("adef_flush", excp_flush, 1'b1);
    idle();
    tick();
    check("adef_flush_once", excp_flush, 1'b0);
    tick();

    // ertn, then a wrong-path beat offered in the shadow cycle
    b = '0;
    b.pc = 32'h1c00_0020;
    b.ertn = 1'b1;
    send(b);
    check("ertn_flush", ertn_flush, 1'b1);
    check("ertn_sys_pending", sys_pending, 1'b1);
    idle();
    tick();
    check("shadow_in_ready", in_ready, 1'b1);
    check("ertn_flush_once", ertn_flush, 1'b0);
    apply(alu(32'h1c00_0024, 5'd9, 32'h99));
    tick();
    idle();
    check("drop_rf_we", rf_we, 1'b0);
    check("drop_fwd", fwd_dest, 5'd0);
    check("drop_count", trace_count, 3'd0);
    tick();
    check("drop_no_push", trace_count, 3'd0);

    // FIFO full with five instructions
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bs[i] = alu(32'h1c00_0100 + 32'(4 * i), 5'(i + 1), $urandom());
      send(bs[i]);
    end
    idle();
    check("full_count", trace_count, 3'd4);
    check("full_in_ready", in_ready, 1'b0);
    check("full_rf_we", rf_we, 1'b0);
    check("full_fwd", fwd_dest, 5'd5);
    repeat (3) tick();
    check("full_hold_count", trace_count, 3'd4);
    check("full_hold_ready", in_ready, 1'b0);
    trace_ready = 1'b1;
    hits = 0;
    got.delete();
    for (int k = 0; k < 8; k++) begin
      if (rf_we) hits++;
      if (trace_valid) got.push_back(trace_pc);
      tick();
    end
    check("drain_records", got.size(), 5);
    check("drain_retire_once", hits, 1);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) check("drain_order", got[i], bs[i].pc);

    // steady push + pop at count 2
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++) bs[i] = alu(32'h1c00_0200 + 32'(4 * i), 5'(i + 10), $urandom());
    for (int i = 0; i < 3; i++) send(bs[i]);
    trace_ready = 1'b1;
    for (int i = 3; i < 9; i++) begin
      send(bs[i]);
      check("pp_count", trace_count, 3'd2);
      check("pp_head", trace_pc, bs[i - 2].pc);
    end
    idle();
    repeat (5) tick();

    // reset with three records queued
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(alu(32'h1c00_0300 + 32'(4 * i), 5'd4, 32'(i)));
    idle();
    tick();
    check("pre_rst_count", trace_count, 3'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_count", trace_count, 3'd0);
    check("mid_rst_valid", trace_valid, 1'b0);
    check("mid_rst_flush", {excp_flush, ertn_flush}, 2'b00);
    tick();

    // randomized traffic; a stalled beat is held until it transfers
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      hold = in_valid && !in_ready && !reset;
      tick();
      reset = ($urandom_range(0, 299) == 0);
      trace_ready = ($urandom_range(0, 9) < 6);
      if (!hold) begin
        if ($urandom_range(0, 9) < 7) apply(rand_beat());
        else idle();
      end
    end
    reset = 1'b0;
    idle();
    trace_ready = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
